// File: rtl/wm_front_panel.sv
// Washing-machine front panel: debounces raw buttons/sensors into clean controller inputs and drives the panel LEDs.
// Latency: raw-to-debounced level is DEBOUNCE_CYCLES cycles (+2 with WM_PANEL_SYNC_EN defined); busy/refund LEDs follow inputs by one cycle.
// Backpressure: none; free-running, every input sampled on every clock. Optional macro WM_PANEL_SYNC_EN adds 2-flop input synchronizers.
module wm_front_panel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BLINK_DIV       = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic lid_Button,
    input  logic coin_Sensor,
    input  logic cancel_Button,
    input  logic mode_Button,
    input  logic idle,
    input  logic ready,
    input  logic soak_Operation,
    input  logic wash_Operation,
    input  logic rinse_Operation,
    input  logic spin_Operation,
    input  logic coin_Return,
    output logic lid,
    output logic coin,
    output logic cancel,
    output logic mode_1,
    output logic mode_2,
    output logic mode_3,
    output logic ready_Led,
    output logic busy_Led,
    output logic refund_Led
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);

    // Bit positions of the four conditioned inputs in the packed vectors below.
    localparam int IDX_LID    = 0;
    localparam int IDX_COIN   = 1;
    localparam int IDX_CANCEL = 2;
    localparam int IDX_MODE   = 3;

    // The debounce counter flips stable on the sample that would make it reach DEBOUNCE_CYCLES.
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_DIV);

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_1    = 2'd1,
        SEL_2    = 2'd2,
        SEL_3    = 2'd3
    } sel_e;

    // The controller's idle status is not needed by the panel logic.
    logic unused_idle;
    assign unused_idle = idle;

    logic [3:0] raw_in;
    logic [3:0] deb_in;

    assign raw_in = {mode_Button, cancel_Button, coin_Sensor, lid_Button};

    // ------------------------------------------------------------------
    // Optional input synchronizers
    // ------------------------------------------------------------------
`ifdef WM_PANEL_SYNC_EN
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;

    // Two-flop synchronizer on each raw pin before it reaches the debouncer.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    assign deb_in = sync2_q;
`else
    assign deb_in = raw_in;
`endif

    // ------------------------------------------------------------------
    // Debouncers
    // ------------------------------------------------------------------
    logic [DW-1:0] deb_cnt_q [4];
    logic [DW-1:0] deb_cnt_d [4];
    logic [3:0]    stable_q;
    logic [3:0]    stable_d;
    logic [3:0]    stable_prev_q;
    logic [3:0]    rise;

    // Count consecutive samples disagreeing with the stable value; adopt the raw value once the run is long enough.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 4; i++) begin
            deb_cnt_d[i] = '0;
            if (deb_in[i] != stable_q[i]) begin
                if (deb_cnt_q[i] >= DEB_LAST) begin
                    stable_d[i]  = deb_in[i];
                    deb_cnt_d[i] = '0;
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    // Debounce state registers; stable_prev_q feeds the rising-edge detectors.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                deb_cnt_q[i] <= '0;
            end
            stable_q      <= '0;
            stable_prev_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
        end
    end

    assign rise = stable_q & ~stable_prev_q;

    // ------------------------------------------------------------------
    // Operation activity tracking
    // ------------------------------------------------------------------
    logic op_active_q;
    logic op_active_d;
    logic op_active_prev_q;
    logic op_fall;

    assign op_active_d = soak_Operation | wash_Operation | rinse_Operation | spin_Operation;

    // Register the OR of the phase outputs and keep one cycle of history to see the cycle finish.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_active_q      <= 1'b0;
            op_active_prev_q <= 1'b0;
        end else begin
            op_active_q      <= op_active_d;
            op_active_prev_q <= op_active_q;
        end
    end

    assign op_fall  = op_active_prev_q & ~op_active_q;
    assign busy_Led = op_active_q;

    // ------------------------------------------------------------------
    // Controller-facing conditioned inputs
    // ------------------------------------------------------------------
    logic mode_pulse;
    logic cancel_pulse;

    assign lid          = stable_q[IDX_LID];
    assign cancel_pulse = rise[IDX_CANCEL];
    assign mode_pulse   = rise[IDX_MODE];
    assign cancel       = cancel_pulse;
    // A coin dropped while a cycle is running is not reported to the controller.
    assign coin         = rise[IDX_COIN] & ~op_active_q;

    // ------------------------------------------------------------------
    // Mode selection FSM
    // ------------------------------------------------------------------
    sel_e sel_q;
    sel_e sel_d;

    // Mode selection state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            sel_q <= SEL_NONE;
        end else begin
            sel_q <= sel_d;
        end
    end

    // Next selection (cancel beats cycle-complete beats a mode press) and one-hot mode outputs.
    always_comb begin
        sel_d  = sel_q;
        mode_1 = 1'b0;
        mode_2 = 1'b0;
        mode_3 = 1'b0;

        if (cancel_pulse) begin
            sel_d = SEL_NONE;
        end else if (op_fall) begin
            sel_d = SEL_NONE;
        end else if (mode_pulse && !op_active_q) begin
            case (sel_q)
                SEL_NONE: sel_d = SEL_1;
                SEL_1:    sel_d = SEL_2;
                SEL_2:    sel_d = SEL_3;
                default:  sel_d = SEL_1;
            endcase
        end

        case (sel_q)
            SEL_1:   mode_1 = 1'b1;
            SEL_2:   mode_2 = 1'b1;
            SEL_3:   mode_3 = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Ready LED with lid-open warning blink
    // ------------------------------------------------------------------
    logic [BW-1:0] blink_cnt_q;
    logic [BW-1:0] blink_cnt_d;
    logic          blink_phase_q;
    logic          blink_phase_d;
    logic          blink_en;

    assign blink_en = ready & stable_q[IDX_LID];

    // Blink timer runs only while ready with the lid open, so each warning starts in its high half.
    always_comb begin
        blink_cnt_d   = '0;
        blink_phase_d = 1'b0;
        if (blink_en) begin
            if (blink_cnt_q >= BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + BW'(1);
                blink_phase_d = blink_phase_q;
            end
        end
    end

    // Blink timer registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign ready_Led = ready & (~stable_q[IDX_LID] | ~blink_phase_q);

    // ------------------------------------------------------------------
    // Refund LED pulse stretcher
    // ------------------------------------------------------------------
    logic [BW-1:0] refund_cnt_q;
    logic [BW-1:0] refund_cnt_d;

    // Each refund pulse (re)loads the stretch timer; it counts down to zero and stops there.
    always_comb begin
        refund_cnt_d = refund_cnt_q;
        if (coin_Return) begin
            refund_cnt_d = BLINK_LOAD;
        end else if (refund_cnt_q != '0) begin
            refund_cnt_d = refund_cnt_q - BW'(1);
        end
    end

    // Refund stretch timer register.
    always_ff @(posedge clock) begin
        if (reset) begin
            refund_cnt_q <= '0;
        end else begin
            refund_cnt_q <= refund_cnt_d;
        end
    end

    assign refund_Led = (refund_cnt_q != '0);

endmodule

// File: tb/tb_wm_front_panel.sv
// Testbench for wm_front_panel: directed scenarios plus randomized inputs against a cycle-indexed reference model.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_wm_front_panel;

    localparam int DEB  = 4;
    localparam int BD   = 8;
`ifdef WM_PANEL_SYNC_EN
    localparam int SL   = 2;
`else
    localparam int SL   = 0;
`endif
    localparam int MAXC = 4096;

    logic clock = 1'b0;
    logic reset, lid_Button, coin_Sensor, cancel_Button, mode_Button, idle, ready;
    logic soak_Operation, wash_Operation, rinse_Operation, spin_Operation, coin_Return;
    logic lid, coin, cancel, mode_1, mode_2, mode_3, ready_Led, busy_Led, refund_Led;

    int checks = 0;
    int errors = 0;

    wm_front_panel #(.DEBOUNCE_CYCLES(DEB), .BLINK_DIV(BD)) dut (
        .clock(clock), .reset(reset),
        .lid_Button(lid_Button), .coin_Sensor(coin_Sensor),
        .cancel_Button(cancel_Button), .mode_Button(mode_Button),
        .idle(idle), .ready(ready),
        .soak_Operation(soak_Operation), .wash_Operation(wash_Operation),
        .rinse_Operation(rinse_Operation), .spin_Operation(spin_Operation),
        .coin_Return(coin_Return),
        .lid(lid), .coin(coin), .cancel(cancel),
        .mode_1(mode_1), .mode_2(mode_2), .mode_3(mode_3),
        .ready_Led(ready_Led), .busy_Led(busy_Led), .refund_Led(refund_Led)
    );

    always #5 clock = ~clock;

    // Reference model: histories indexed by cycle number; cycle c is the interval ending at the (c+1)-th rising edge.
    int cyc   = 0;
    int m_rel = 0;              // first cycle after the most recent reset
    bit raw_h [4][MAXC];
    bit deb_h [4][MAXC];
    bit m_st [4];               // debounced values in the current cycle
    bit m_pr [4];               // debounced values one cycle earlier
    int m_chg [4];              // first sample index that may count toward the next change
    bit m_busy, m_busy_pr;
    int m_sel = 0;              // 0 = nothing, k = mode_k
    bit m_rl_pr;
    int m_bstart = 0;
    int m_ret = -1000;          // cycle of latest refund pulse

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [2:0] exp_mode();
        case (m_sel)
            1:       return 3'b100;
            2:       return 3'b010;
            3:       return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic exp_ready_led();
        int st;
        if (ready !== 1'b1) return 1'b0;
        if (!m_st[0]) return 1'b1;
        st = m_rl_pr ? m_bstart : cyc;
        return (((cyc - st) / BD) % 2) == 0;
    endfunction

    task automatic check_all();
        chk1("lid", lid, m_st[0]);
        chk1("coin", coin, m_st[1] & ~m_pr[1] & ~m_busy);
        chk1("cancel", cancel, m_st[2] & ~m_pr[2]);
        chk3("mode", {mode_1, mode_2, mode_3}, exp_mode());
        chk1("busy_Led", busy_Led, m_busy);
        chk1("ready_Led", ready_Led, exp_ready_led());
        chk1("refund_Led", refund_Led, (cyc - m_ret >= 1) && (cyc - m_ret <= BD));
    endtask

    // Advance the model across one rising edge using the inputs sampled there.
    task automatic model_step();
        int  c;
        bit  cpul, fall, medge, rl, d, ok;
        c = cyc;
        raw_h[0][c] = lid_Button;
        raw_h[1][c] = coin_Sensor;
        raw_h[2][c] = cancel_Button;
        raw_h[3][c] = mode_Button;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                m_st[i]  = 1'b0;
                m_pr[i]  = 1'b0;
                m_chg[i] = c + 1;
            end
            m_busy = 1'b0; m_busy_pr = 1'b0; m_sel = 0; m_rl_pr = 1'b0;
            m_ret = -1000; m_rel = c + 1;
        end else begin
            cpul  = m_st[2] & ~m_pr[2];
            medge = m_st[3] & ~m_pr[3];
            fall  = m_busy_pr & ~m_busy;
            if (cpul)                    m_sel = 0;
            else if (fall)               m_sel = 0;
            else if (medge && !m_busy)   m_sel = (m_sel % 3) + 1;
            rl = ready & m_st[0];
            if (rl && !m_rl_pr) m_bstart = c;
            m_rl_pr = rl;
            if (coin_Return) m_ret = c;
            m_busy_pr = m_busy;
            m_busy    = soak_Operation | wash_Operation | rinse_Operation | spin_Operation;
            for (int i = 0; i < 4; i++) begin
                d = (c - SL >= m_rel) ? raw_h[i][c - SL] : 1'b0;
                deb_h[i][c] = d;
                m_pr[i] = m_st[i];
                if (d != m_st[i] && (c - DEB + 1) >= m_chg[i]) begin
                    ok = 1'b1;
                    for (int k = c - DEB + 1; k <= c; k++)
                        if (deb_h[i][k] == m_st[i]) ok = 1'b0;
                    if (ok) begin
                        m_st[i]  = d;
                        m_chg[i] = c + 1;
                    end
                end
            end
        end
        cyc = c + 1;
    endtask

    task automatic half();
        @(negedge clock);
        check_all();
    endtask

    task automatic adv();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic tick();
        half();
        adv();
    endtask

    task automatic press_mode();
        mode_Button = 1'b1;
        repeat (6 + SL) tick();
        mode_Button = 1'b0;
        repeat (6 + SL) tick();
    endtask

    logic [2:0] mode_seq [4];
    logic [3:0] rb;
    int         h_btn [4];
    int         h_ops, h_rdy;

    initial begin
        mode_seq = '{3'b100, 3'b010, 3'b001, 3'b100};
        reset = 1'b1; lid_Button = 1'b0; coin_Sensor = 1'b0; cancel_Button = 1'b0;
        mode_Button = 1'b0; idle = 1'b1; ready = 1'b0; coin_Return = 1'b0;
        soak_Operation = 1'b0; wash_Operation = 1'b0; rinse_Operation = 1'b0; spin_Operation = 1'b0;

        // Reset
        adv();
        repeat (2) tick();
        reset = 1'b0;
        half();
        chk3("reset_inputs", {lid, coin, cancel}, 3'b000);
        chk3("reset_mode", {mode_1, mode_2, mode_3}, 3'b000);
        chk3("reset_leds", {ready_Led, busy_Led, refund_Led}, 3'b000);
        adv();

        // Lid debounce latency
        lid_Button = 1'b1;
        for (int k = 0; k < 8 + SL; k++) begin
            half(); chk1("lid_latency", lid, k >= 4 + SL); adv();
        end
        lid_Button = 1'b0;
        repeat (8 + SL) tick();
        // Short glitch never propagates
        lid_Button = 1'b1;
        repeat (3) tick();
        lid_Button = 1'b0;
        for (int k = 0; k < 10; k++) begin
            half(); chk1("lid_glitch", lid, 1'b0); adv();
        end

        // Coin pulse, then suppressed while an operation runs
        coin_Sensor = 1'b1;
        for (int k = 0; k < 8 + SL; k++) begin
            half(); chk1("coin_pulse", coin, k == 4 + SL); adv();
        end
        coin_Sensor = 1'b0;
        repeat (8 + SL) tick();
        wash_Operation = 1'b1;
        repeat (2) tick();
        coin_Sensor = 1'b1;
        for (int k = 0; k < 8 + SL; k++) begin
            half(); chk1("coin_locked", coin, 1'b0); adv();
        end
        coin_Sensor = 1'b0; wash_Operation = 1'b0;
        repeat (8 + SL) tick();

        // Mode sequence and cancel
        idle = 1'b1;
        for (int p = 0; p < 4; p++) begin
            press_mode();
            half(); chk3("mode_seq", {mode_1, mode_2, mode_3}, mode_seq[p]); adv();
        end
        cancel_Button = 1'b1;
        for (int k = 0; k < 8 + SL; k++) begin
            half();
            chk1("cancel_pulse", cancel, k == 4 + SL);
            chk3("mode_cancel", {mode_1, mode_2, mode_3}, (k >= 5 + SL) ? 3'b000 : 3'b100);
            adv();
        end
        cancel_Button = 1'b0;
        repeat (8 + SL) tick();

        // Mode lock during operation, release on cycle completion
        press_mode();
        press_mode();
        soak_Operation = 1'b1;
        repeat (2) tick();
        press_mode();
        press_mode();
        half(); chk3("mode_locked", {mode_1, mode_2, mode_3}, 3'b010); adv();
        soak_Operation = 1'b0;
        for (int k = 0; k < 4; k++) begin
            half();
            chk1("busy_fall", busy_Led, k == 0);
            chk3("mode_release", {mode_1, mode_2, mode_3}, (k >= 2) ? 3'b000 : 3'b010);
            adv();
        end

        // Ready LED steady, then lid-open blink
        ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            half(); chk1("ready_steady", ready_Led, 1'b1); adv();
        end
        lid_Button = 1'b1;
        for (int k = 0; k < 36 + SL; k++) begin
            half();
            chk1("ready_blink", ready_Led, (k < 4 + SL) ? 1'b1 : ((((k - 4 - SL) / BD) % 2) == 0));
            adv();
        end
        // Refund stretch
        coin_Return = 1'b1;
        for (int k = 0; k < 12; k++) begin
            half(); chk1("refund_stretch", refund_Led, (k >= 1) && (k <= BD)); adv();
            coin_Return = 1'b0;
        end
        lid_Button = 1'b0; ready = 1'b0;
        repeat (8 + SL) tick();

        // Reset in the middle of a debounce count
        lid_Button = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 7 + SL; k++) begin
            half(); chk1("lid_after_reset", lid, k >= 4 + SL); adv();
        end
        lid_Button = 1'b0;
        repeat (8 + SL) tick();

        // Randomized traffic against the model
        for (int i = 0; i < 4; i++) h_btn[i] = 0;
        h_ops = 0; h_rdy = 0; rb = 4'b0;
        for (int n = 0; n < 700; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (h_btn[i] == 0) begin
                    rb[i]    = 1'($urandom_range(0, 1));
                    h_btn[i] = $urandom_range(1, 8);
                end else begin
                    h_btn[i]--;
                end
            end
            {mode_Button, cancel_Button, coin_Sensor, lid_Button} = rb;
            if (h_ops == 0) begin
                {soak_Operation, wash_Operation, rinse_Operation, spin_Operation} =
                    ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
                h_ops = $urandom_range(2, 25);
            end else begin
                h_ops--;
            end
            if (h_rdy == 0) begin
                ready = 1'($urandom_range(0, 1));
                h_rdy = $urandom_range(1, 40);
            end else begin
                h_rdy--;
            end
            coin_Return = ($urandom_range(0, 11) == 0);
            idle        = 1'($urandom_range(0, 1));
            reset       = ($urandom_range(0, 249) == 0);
            tick();
        end

        reset = 1'b0; lid_Button = 1'b0; coin_Sensor = 1'b0; cancel_Button = 1'b0; mode_Button = 1'b0;
        soak_Operation = 1'b0; wash_Operation = 1'b0; rinse_Operation = 1'b0; spin_Operation = 1'b0;
        coin_Return = 1'b0; ready = 1'b0;
        repeat (12) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
